jam_enum_param: RTL and testbench

- Parametrised exhaustive job-assignment solver for N workers and N jobs.
- Enumerates all N! permutations in lexicographic order, using the next-permutation algorithm: pivot search, swap, then suffix reverse.
- For each permutation it queries an external combinational cost table one worker per cycle, accumulates the total, and tracks the minimum total, how many permutations reach it, and the first permutation that reaches it.
- Successor of the fixed 8x8 solver: adds size and width parameters, start/busy handshake, re-run without reset, and an optional best-assignment output.

---
 rtl/jam_enum_param.sv | 225 ++++++++++++++++++++++
 tb/tb_jam_enum_param.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jam_enum_param.sv
// jam_enum_param: exhaustive N-worker / N-job assignment solver.
// Walks every permutation in lexicographic order (pivot, swap, suffix reverse),
// sums one cost-table entry per cycle, and keeps the minimum total and the
// number of permutations that reach it.
// Optional feature macro: JAM_BEST_PERM_EN adds the BestPerm output, which
// holds the first optimal assignment found.
module jam_enum_param #(
  parameter int unsigned N      = 8,
  parameter int unsigned IDX_W  = 3,
  parameter int unsigned COST_W = 7,
  parameter int unsigned SUM_W  = 10,
  parameter int unsigned MC_W   = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Start,
  output logic [IDX_W-1:0]  W,
  output logic [IDX_W-1:0]  J,
  input  logic [COST_W-1:0] Cost,
  output logic              Busy,
  output logic              Valid,
  output logic [SUM_W-1:0]  MinCost,
  output logic [MC_W-1:0]   MatchCount
`ifdef JAM_BEST_PERM_EN
  ,
  output logic [N*IDX_W-1:0] BestPerm
`endif
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ACCUM   = 3'd1;
  localparam logic [2:0] S_EVAL    = 3'd2;
  localparam logic [2:0] S_PIVOT   = 3'd3;
  localparam logic [2:0] S_FIND    = 3'd4;
  localparam logic [2:0] S_SWAP    = 3'd5;
  localparam logic [2:0] S_REVERSE = 3'd6;
  localparam logic [2:0] S_DONE    = 3'd7;

  localparam logic [IDX_W-1:0] LAST  = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] LAST2 = IDX_W'(N - 2);

  logic [2:0]       state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;      // ACCUM k, PIVOT i, FIND j, REVERSE lo
  logic [IDX_W-1:0] hi_q, hi_d;
  logic [IDX_W-1:0] piv_q, piv_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [IDX_W-1:0] perm_q [N];
  logic [IDX_W-1:0] perm_d [N];
  logic [SUM_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0] w_q, w_d, j_q, j_d;
  logic             busy_q, busy_d, valid_q, valid_d;
  logic [SUM_W-1:0] min_q, min_d;
  logic [MC_W-1:0]  mc_q, mc_d;
  logic [IDX_W-1:0] cnt_inc;
  logic             desc;
`ifdef JAM_BEST_PERM_EN
  logic [N*IDX_W-1:0] best_q, best_d;
  assign BestPerm = best_q;
`endif

  assign cnt_inc    = cnt_q + 1'b1;
  assign W          = w_q;
  assign J          = j_q;
  assign Busy       = busy_q;
  assign Valid      = valid_q;
  assign MinCost    = min_q;
  assign MatchCount = mc_q;

  // Next-state and next-register values for the enumeration FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    piv_d   = piv_q;
    sel_d   = sel_q;
    perm_d  = perm_q;
    acc_d   = acc_q;
    w_d     = w_q;
    j_d     = j_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    min_d   = min_q;
    mc_d    = mc_q;
`ifdef JAM_BEST_PERM_EN
    best_d  = best_q;
`endif
    desc = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (perm_q[i] != IDX_W'(N - 1 - i)) desc = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          for (int i = 0; i < N; i++) perm_d[i] = IDX_W'(i);
          acc_d   = '0;
          min_d   = '1;
          mc_d    = '0;
          valid_d = 1'b0;
          busy_d  = 1'b1;
          w_d     = '0;
          j_d     = '0;
          cnt_d   = '0;
`ifdef JAM_BEST_PERM_EN
          best_d  = '0;
`endif
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        acc_d = acc_q + SUM_W'(Cost);
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          w_d     = '0;
          j_d     = perm_q[0];
          state_d = S_EVAL;
        end else begin
          cnt_d = cnt_inc;
          w_d   = cnt_inc;
          j_d   = perm_q[cnt_inc];
        end
      end
      S_EVAL: begin
        if (acc_q < min_q) begin
          min_d = acc_q;
          mc_d  = MC_W'(1);
`ifdef JAM_BEST_PERM_EN
          for (int i = 0; i < N; i++) best_d[i*IDX_W +: IDX_W] = perm_q[i];
`endif
        end else if (acc_q == min_q) begin
          mc_d = mc_q + 1'b1;
        end
        if (desc) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = LAST2;
          state_d = S_PIVOT;
        end
      end
      S_PIVOT: begin
        // a non-descending permutation always has a pivot, so i never underflows
        if (perm_q[cnt_q] < perm_q[cnt_inc]) begin
          piv_d   = cnt_q;
          sel_d   = cnt_inc;
          cnt_d   = cnt_inc;
          state_d = S_FIND;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_FIND: begin
        if ((perm_q[cnt_q] > perm_q[piv_q]) && (perm_q[cnt_q] < perm_q[sel_q])) sel_d = cnt_q;
        if (cnt_q == LAST) state_d = S_SWAP;
        else               cnt_d   = cnt_inc;
      end
      S_SWAP: begin
        perm_d[piv_q] = perm_q[sel_q];
        perm_d[sel_q] = perm_q[piv_q];
        cnt_d   = piv_q + 1'b1;
        hi_d    = LAST;
        state_d = S_REVERSE;
      end
      S_REVERSE: begin
        if (cnt_q < hi_q) begin
          perm_d[cnt_q] = perm_q[hi_q];
          perm_d[hi_q]  = perm_q[cnt_q];
          cnt_d = cnt_inc;
          hi_d  = hi_q - 1'b1;
        end else begin
          acc_d   = '0;
          cnt_d   = '0;
          w_d     = '0;
          j_d     = perm_q[0];
          state_d = S_ACCUM;
        end
      end
      S_DONE: begin
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, asynchronously cleared by RST
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      piv_q   <= '0;
      sel_q   <= '0;
      for (int i = 0; i < N; i++) perm_q[i] <= IDX_W'(i);
      acc_q   <= '0;
      w_q     <= '0;
      j_q     <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      min_q   <= '1;
      mc_q    <= '0;
`ifdef JAM_BEST_PERM_EN
      best_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      piv_q   <= piv_d;
      sel_q   <= sel_d;
      perm_q  <= perm_d;
      acc_q   <= acc_d;
      w_q     <= w_d;
      j_q     <= j_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      min_q   <= min_d;
      mc_q    <= mc_d;
`ifdef JAM_BEST_PERM_EN
      best_q  <= best_d;
`endif
    end
  end

endmodule

// File: tb/tb_jam_enum_param.sv
// Bench for jam_enum_param: four solver sizes (N=2,3,4,6) share one cost
// matrix; one size is active at a time. A brute-force model enumerates every
// index tuple in lexicographic order and keeps the permutations among them.
module tb_jam_enum_param;

  logic CLK, RST, start;
  logic [6:0] cost_m [8][8];
  int cur;
  int n_cmp, n_err;
  bit running;

  logic [2:0] w2, j2, w3, j3, w4, j4, w6, j6;
  logic [6:0] c2, c3, c4, c6;
  logic b2, b3, b4, b6, v2, v3, v4, v6;
  logic [9:0] mn2, mn3, mn4, mn6;
  logic [15:0] mc2, mc3, mc4, mc6;
`ifdef JAM_BEST_PERM_EN
  logic [5:0]  bp2;
  logic [8:0]  bp3;
  logic [11:0] bp4;
  logic [17:0] bp6;
`endif

  assign c2 = cost_m[w2][j2];
  assign c3 = cost_m[w3][j3];
  assign c4 = cost_m[w4][j4];
  assign c6 = cost_m[w6][j6];

  jam_enum_param #(.N(2)) u2 (.CLK(CLK), .RST(RST), .Start(start && cur == 2), .W(w2), .J(j2),
    .Cost(c2), .Busy(b2), .Valid(v2), .MinCost(mn2), .MatchCount(mc2)
`ifdef JAM_BEST_PERM_EN
    , .BestPerm(bp2)
`endif
  );
  jam_enum_param #(.N(3)) u3 (.CLK(CLK), .RST(RST), .Start(start && cur == 3), .W(w3), .J(j3),
    .Cost(c3), .Busy(b3), .Valid(v3), .MinCost(mn3), .MatchCount(mc3)
`ifdef JAM_BEST_PERM_EN
    , .BestPerm(bp3)
`endif
  );
  jam_enum_param #(.N(4)) u4 (.CLK(CLK), .RST(RST), .Start(start && cur == 4), .W(w4), .J(j4),
    .Cost(c4), .Busy(b4), .Valid(v4), .MinCost(mn4), .MatchCount(mc4)
`ifdef JAM_BEST_PERM_EN
    , .BestPerm(bp4)
`endif
  );
  jam_enum_param #(.N(6)) u6 (.CLK(CLK), .RST(RST), .Start(start && cur == 6), .W(w6), .J(j6),
    .Cost(c6), .Busy(b6), .Valid(v6), .MinCost(mn6), .MatchCount(mc6)
`ifdef JAM_BEST_PERM_EN
    , .BestPerm(bp6)
`endif
  );

  // outputs of the currently active instance
  logic [2:0]  a_w, a_j;
  logic        a_busy, a_valid;
  logic [9:0]  a_min;
  logic [15:0] a_mc;
  logic [23:0] a_bp;
  always_comb begin
    a_w = w4; a_j = j4; a_busy = b4; a_valid = v4; a_min = mn4; a_mc = mc4; a_bp = '0;
    case (cur)
      2: begin a_w = w2; a_j = j2; a_busy = b2; a_valid = v2; a_min = mn2; a_mc = mc2; end
      3: begin a_w = w3; a_j = j3; a_busy = b3; a_valid = v3; a_min = mn3; a_mc = mc3; end
      6: begin a_w = w6; a_j = j6; a_busy = b6; a_valid = v6; a_min = mn6; a_mc = mc6; end
      default: ;
    endcase
`ifdef JAM_BEST_PERM_EN
    case (cur)
      2: a_bp = 24'(bp2);
      3: a_bp = 24'(bp3);
      6: a_bp = 24'(bp6);
      default: a_bp = 24'(bp4);
    endcase
`endif
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model results
  int m_min, m_cnt;
  logic [23:0] m_bp;
  int m_perms[$];
  int dut_seq[$];
  int hw[8], hj[8];

  function automatic void compute_model(input int n);
    int d[8];
    int total, r, s, code, used;
    bit ok;
    total = 1;
    for (int i = 0; i < n; i++) total *= n;
    m_min = 1 << 30; m_cnt = 0; m_bp = '0; m_perms.delete();
    for (int t = 0; t < total; t++) begin
      r = t;
      for (int i = n - 1; i >= 0; i--) begin d[i] = r % n; r = r / n; end
      used = 0; ok = 1'b1;
      for (int i = 0; i < n; i++) begin
        if (((used >> d[i]) & 1) != 0) ok = 1'b0;
        used = used | (1 << d[i]);
      end
      if (ok) begin
        s = 0; code = 0;
        for (int i = 0; i < n; i++) begin
          s += int'(cost_m[i][d[i]]);
          code = code * 8 + d[i];
        end
        m_perms.push_back(code);
        if (s < m_min) begin
          m_min = s; m_cnt = 1; m_bp = '0;
          for (int i = 0; i < n; i++) m_bp[i*3 +: 3] = 3'(d[i]);
        end else if (s == m_min) begin
          m_cnt++;
        end
      end
    end
  endfunction

  // per-cycle checks of the active instance
  always @(negedge CLK) begin
    if (!RST && cur != 0) begin
      chk("w_in_range", (int'(a_w) < cur) ? 1 : 0, 1);
      chk("j_in_range", (int'(a_j) < cur) ? 1 : 0, 1);
      if (running) begin
        bit hit;
        int code;
        for (int i = 0; i < 7; i++) begin hw[i] = hw[i+1]; hj[i] = hj[i+1]; end
        hw[7] = int'(a_w); hj[7] = int'(a_j);
        hit = 1'b1; code = 0;
        for (int k = 0; k < cur; k++) begin
          if (hw[8 - cur + k] != k) hit = 1'b0;
          code = code * 8 + hj[8 - cur + k];
        end
        if (hit) dut_seq.push_back(code);
        chk("busy_xor_valid", a_busy ^ a_valid, 1);
        if (a_valid) begin
          chk("min_vs_model", a_min, m_min);
          chk("count_vs_model", a_mc, m_cnt);
`ifdef JAM_BEST_PERM_EN
          chk("bestperm_vs_model", a_bp, m_bp);
`endif
          running = 1'b0;
        end
      end
    end
  end

  task automatic run_test(input int n, input int lim, input int poke);
    cur = n;
    compute_model(n);
    dut_seq.delete();
    for (int i = 0; i < 8; i++) begin hw[i] = 99; hj[i] = 99; end
    @(posedge CLK); #2 start = 1'b1;
    @(posedge CLK); #2 start = 1'b0;
    running = 1'b1;
    @(negedge CLK); #1;
    chk("busy_after_start", a_busy, 1);
    chk("valid_low_in_run", a_valid, 0);
    for (int c = 0; c < lim && running; c++) begin
      @(posedge CLK); #2;
      start = (c == poke);
    end
    start = 1'b0;
    if (running) begin
      chk("run_timeout", 0, 1);
      running = 1'b0;
    end
    @(negedge CLK);
  endtask

  task automatic check_reset_vals;
    chk("rst_w", a_w, 0);
    chk("rst_j", a_j, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_valid", a_valid, 0);
    chk("rst_min", a_min, 1023);
    chk("rst_count", a_mc, 0);
`ifdef JAM_BEST_PERM_EN
    chk("rst_bestperm", a_bp, 0);
`endif
  endtask

  initial begin
    n_cmp = 0; n_err = 0; running = 1'b0; start = 1'b0; cur = 4;
    for (int i = 0; i < 8; i++) for (int k = 0; k < 8; k++) cost_m[i][k] = 7'd0;
    RST = 1'b1;
    #1;
    check_reset_vals();
    repeat (3) @(posedge CLK);
    #2 RST = 1'b0;

    // N=2, [[1,2],[3,4]]: both assignments total 5
    cost_m[0][0] = 7'd1; cost_m[0][1] = 7'd2; cost_m[1][0] = 7'd3; cost_m[1][1] = 7'd4;
    run_test(2, 200, -1);
    chk("n2_model_min", m_min, 5);
    chk("n2_min", a_min, 5);
    chk("n2_count", a_mc, 2);
    chk("n2_valid_held", a_valid, 1);
`ifdef JAM_BEST_PERM_EN
    chk("n2_bestperm", a_bp, 24'h8);
`endif

    // N=3, diag 0 / off-diag 10, with a Start poked while busy
    for (int i = 0; i < 3; i++) for (int k = 0; k < 3; k++) cost_m[i][k] = (i == k) ? 7'd0 : 7'd10;
    run_test(3, 500, 10);
    chk("n3_min", a_min, 0);
    chk("n3_count", a_mc, 1);
`ifdef JAM_BEST_PERM_EN
    chk("n3_bestperm", a_bp, 24'd136);
`endif
    chk("n3_seq_len", dut_seq.size(), 6);
    chk("n3_model_first", m_perms[0], 10);
    chk("n3_model_last", m_perms[5], 136);
    for (int i = 0; i < 6 && i < dut_seq.size(); i++) chk("n3_seq_order", dut_seq[i], m_perms[i]);

    // N=4, all 5, then a second Start without reset
    for (int i = 0; i < 4; i++) for (int k = 0; k < 4; k++) cost_m[i][k] = 7'd5;
    for (int r = 0; r < 2; r++) begin
      run_test(4, 2000, -1);
      chk("n4_min", a_min, 20);
      chk("n4_count", a_mc, 24);
`ifdef JAM_BEST_PERM_EN
      chk("n4_bestperm", a_bp, 24'd1672);
`endif
    end

    // reset while accumulating aborts the run immediately
    cur = 4;
    @(posedge CLK); #2 start = 1'b1;
    @(posedge CLK); #2 start = 1'b0;
    @(posedge CLK); #2;
    chk("n4_mid_busy", a_busy, 1);
    RST = 1'b1;
    #1;
    check_reset_vals();
    @(posedge CLK); #2 RST = 1'b0;
    run_test(4, 2000, -1);
    chk("n4_after_abort_count", a_mc, 24);

    // N=6 random matrix against the model
    for (int i = 0; i < 6; i++) for (int k = 0; k < 6; k++) cost_m[i][k] = 7'($urandom_range(0, 127));
    run_test(6, 30000, -1);
    chk("n6_rand_min", a_min, m_min);
    chk("n6_rand_count", a_mc, m_cnt);

    // N=6 all-maximum costs: widest totals
    for (int i = 0; i < 6; i++) for (int k = 0; k < 6; k++) cost_m[i][k] = 7'd127;
    run_test(6, 30000, -1);
    chk("n6_max_min", a_min, 762);
    chk("n6_max_count", a_mc, 720);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
